adder_error_monitor: RTL and testbench

- Streaming consumer for approximate-adder characterisation. Sits downstream of an adder under test (nBitRcpa1/2/3 or any N-bit approximate adder) and receives exact/approximate sum pairs.
- Accumulates error statistics in hardware, so exhaustive sweeps need no per-sample CSV logging: sample count, erroneous-sample count, summed error distance, maximum error distance and an overflow flag.
- Results are read once a sweep completes.

---
 rtl/adder_eval_pkg.sv | 39 +++
 rtl/adder_error_monitor_abs_diff.sv | 13 +
 rtl/adder_error_monitor.sv | 122 ++++++++++++
 tb/tb_adder_error_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for adder error-metric blocks.
// Holds the monitor state encoding and saturating arithmetic.
package adder_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } state_e;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int SAT_W     = 64;

  localparam logic [SAT_W:0] SAT_ONE = 1;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_t;

  // Add and clamp to 2^w-1; sat flags a clamped update.
  function automatic sat_t sat_inc(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] inc,
    input int unsigned      w
  );
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    sat_t           r;
    lim   = (SAT_ONE << w) - SAT_ONE;
    s     = {1'b0, acc} + {1'b0, inc};
    r.sat = (s > lim);
    r.val = r.sat ? lim[SAT_W-1:0] : s[SAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/adder_error_monitor_abs_diff.sv
// Unsigned |a-b| without wrap: larger minus smaller.
// Combinational; reusable by other error-metric blocks.
module abs_diff #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/adder_error_monitor.sv
// Streaming error-statistics monitor for approximate adders.
// Two stages: error distance register, then accumulators.
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [N-1:0]       exact_sum,
  input  logic [N-1:0]       approx_sum,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   error_count,
  output logic [CNT_W+N-1:0] sum_ed,
  output logic [N-1:0]       max_ed,
  output logic               overflow,
  output logic               done
);

  localparam int SW = CNT_W + N;

  state_e             state_q, state_d;
  logic               v1_q, v1_d;
  logic [N-1:0]       ed1_q, ed1_d;
  logic               err1_q, err1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   errc_q, errc_d;
  logic [SW-1:0]      sum_q, sum_d;
  logic [N-1:0]       max_q, max_d;
  logic               ovf_q, ovf_d;

  logic [N-1:0] ed;
  logic         acc;
  sat_t         cnt_s, errc_s, sum_s;

  abs_diff #(.W(N)) u_abs_diff (
    .a_i (exact_sum),
    .b_i (approx_sum),
    .d_o (ed)
  );

  assign in_ready = (state_q == ACCUM);
  assign done     = (state_q == DONE);
  assign acc      = in_valid && in_ready;

  assign cnt_s  = sat_inc(SAT_W'(cnt_q), SAT_W'(1'b1), CNT_W);
  assign errc_s = sat_inc(SAT_W'(errc_q), SAT_W'(err1_q), CNT_W);
  assign sum_s  = sat_inc(SAT_W'(sum_q), SAT_W'(ed1_q), SW);

  always_comb begin
    state_d = state_q;
    v1_d    = acc;
    ed1_d   = ed;
    err1_d  = (ed != '0);
    cnt_d   = cnt_q;
    errc_d  = errc_q;
    sum_d   = sum_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    if (v1_q) begin
      cnt_d  = cnt_s.val[CNT_W-1:0];
      errc_d = errc_s.val[CNT_W-1:0];
      sum_d  = sum_s.val[SW-1:0];
      max_d  = (ed1_q > max_q) ? ed1_q : max_q;
      ovf_d  = ovf_q | cnt_s.sat
             | errc_s.sat | sum_s.sat;
    end
    unique case (state_q)
      IDLE:    state_d = IDLE;
      ACCUM:   if (acc && in_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Restart wins over in_last and drops stage 1.
    if (start) begin
      state_d = ACCUM;
      v1_d    = 1'b0;
      cnt_d   = '0;
      errc_d  = '0;
      sum_d   = '0;
      max_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v1_q    <= 1'b0;
      ed1_q   <= '0;
      err1_q  <= 1'b0;
      cnt_q   <= '0;
      errc_q  <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      ed1_q   <= ed1_d;
      err1_q  <= err1_d;
      cnt_q   <= cnt_d;
      errc_q  <= errc_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sample_count = cnt_q;
  assign error_count  = errc_q;
  assign sum_ed       = sum_q;
  assign max_ed       = max_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomized bench for adder_error_monitor (CNT_W=16 and 4).
// Reference keeps the list of finished samples per sweep.
module tb_adder_error_monitor;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last;
  logic [7:0] exact_sum, approx_sum;

  logic        rdy16, ov16, dn16;
  logic [15:0] sc16, ec16;
  logic [23:0] se16;
  logic [7:0]  me16;

  logic        rdy4, ov4, dn4;
  logic [3:0]  sc4, ec4;
  logic [11:0] se4;
  logic [7:0]  me4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: 0 idle, 1 accum, 2 flush, 3 done
  int mst = 0;
  int vis[$];
  bit pend_v = 0;
  int pend_ed = 0;

  always #5 clk = ~clk;

  adder_error_monitor #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdy16),
    .in_last(in_last),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
    .sample_count(sc16), .error_count(ec16),
    .sum_ed(se16), .max_ed(me16),
    .overflow(ov16), .done(dn16)
  );

  adder_error_monitor #(.N(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_last(in_last),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
    .sample_count(sc4), .error_count(ec4),
    .sum_ed(se4), .max_ed(me4),
    .overflow(ov4), .done(dn4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic expect_stats(input int cw,
                              output longint c,
                              output longint e,
                              output longint s,
                              output longint m,
                              output longint o);
    longint n, ne, sm, mx, lc, ls;
    n = vis.size(); ne = 0; sm = 0; mx = 0;
    foreach (vis[i]) begin
      if (vis[i] != 0) ne++;
      sm += vis[i];
      if (vis[i] > mx) mx = vis[i];
    end
    lc = (longint'(1) << cw) - 1;
    ls = (longint'(1) << (cw + 8)) - 1;
    o = (n > lc || ne > lc || sm > ls) ? 1 : 0;
    c = (n > lc) ? lc : n;
    e = (ne > lc) ? lc : ne;
    s = (sm > ls) ? ls : sm;
    m = mx;
  endtask

  task automatic compare_all();
    longint c, e, s, m, o;
    expect_stats(16, c, e, s, m, o);
    check("cnt16", sc16, c);
    check("err16", ec16, e);
    check("sum16", se16, s);
    check("max16", me16, m);
    check("ovf16", ov16, o);
    check("rdy16", rdy16, mst == 1);
    check("done16", dn16, mst == 3);
    expect_stats(4, c, e, s, m, o);
    check("cnt4", sc4, c);
    check("err4", ec4, e);
    check("sum4", se4, s);
    check("max4", me4, m);
    check("ovf4", ov4, o);
    check("rdy4", rdy4, mst == 1);
    check("done4", dn4, mst == 3);
  endtask

  task automatic cyc(input bit r, input bit s,
                     input bit v, input bit l,
                     input logic [7:0] e,
                     input logic [7:0] a);
    bit acc;
    rst = r; start = s; in_valid = v; in_last = l;
    exact_sum = e; approx_sum = a;
    acc = v && (mst == 1);
    @(posedge clk); #1;
    if (r) begin
      mst = 0; vis.delete(); pend_v = 0;
    end else if (s) begin
      mst = 1; vis.delete(); pend_v = 0;
    end else begin
      if (pend_v) vis.push_back(pend_ed);
      pend_v  = acc;
      pend_ed = (e > a) ? int'(e - a) : int'(a - e);
      if (mst == 1 && acc && l) mst = 2;
      else if (mst == 2) mst = 3;
    end
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 8'd0, 8'd0);
  endtask

  initial begin
    logic [7:0] e, a;
    bit v, l, s, r;
    rst = 1; start = 1; in_valid = 1; in_last = 0;
    exact_sum = 8'd7; approx_sum = 8'd3;

    // reset overrides start and in_valid
    cyc(1, 1, 1, 0, 8'd7, 8'd3);
    cyc(1, 1, 1, 0, 8'd7, 8'd3);
    check("rst_rdy", rdy16, 0);
    check("rst_cnt", sc16, 0);
    idle(1);

    // basic sweep
    cyc(0, 1, 0, 0, 8'd0, 8'd0);
    cyc(0, 0, 1, 0, 8'd10, 8'd10);
    cyc(0, 0, 1, 0, 8'd20, 8'd16);
    cyc(0, 0, 1, 0, 8'd5, 8'd9);
    cyc(0, 0, 1, 1, 8'd255, 8'd0);
    check("bs_done_early", dn16, 0);
    idle(1);
    check("bs_done", dn16, 1);
    check("bs_cnt", sc16, 4);
    check("bs_err", ec16, 3);
    check("bs_sum", se16, 263);
    check("bs_max", me16, 255);
    check("bs_ovf", ov16, 0);

    // back-pressure in DONE then IDLE
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 1, 8'd7, 8'd3);
    check("bp_done_cnt", sc16, 4);
    check("bp_done_rdy", rdy16, 0);
    cyc(1, 0, 0, 0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 1, 8'd7, 8'd3);
    check("bp_idle_cnt", sc16, 0);
    check("bp_idle_done", dn16, 0);

    // saturation on the CNT_W=4 instance
    cyc(0, 1, 0, 0, 8'd0, 8'd0);
    for (int i = 0; i < 17; i++) begin
      e = 8'($urandom_range(1, 255));
      cyc(0, 0, 1, i == 16, e, e - 8'd1);
    end
    idle(2);
    check("sat_cnt", sc4, 15);
    check("sat_err", ec4, 15);
    check("sat_sum", se4, 17);
    check("sat_ovf", ov4, 1);
    check("sat_ovf16", ov16, 0);

    // restart inside ACCUM drops the concurrent sample
    cyc(0, 1, 0, 0, 8'd0, 8'd0);
    cyc(0, 0, 1, 0, 8'd3, 8'd1);
    cyc(0, 0, 1, 0, 8'd4, 8'd9);
    cyc(0, 1, 1, 1, 8'd9, 8'd1);
    idle(1);
    check("rs_cnt", sc16, 0);
    check("rs_sum", se16, 0);
    check("rs_rdy", rdy16, 1);

    // reset mid-sweep with stage 1 occupied
    cyc(0, 0, 1, 0, 8'd9, 8'd1);
    cyc(1, 0, 0, 0, 8'd0, 8'd0);
    check("mr_rdy", rdy16, 0);
    idle(2);
    check("mr_cnt", sc16, 0);
    check("mr_max", me16, 0);

    // random sweeps
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 0, 0, 8'd0, 8'd0);
      for (int i = 0; i < 60; i++) begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 23) == 0);
        s = ($urandom_range(0, 79) == 0);
        r = ($urandom_range(0, 149) == 0);
        e = 8'($urandom);
        a = ($urandom_range(0, 2) == 0) ? e : 8'($urandom);
        cyc(r, s, v, l, e, a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
